// File: rtl/ifetch_align_buffer.sv
// Fetch-side halfword realignment buffer between word-aligned I-memory and decode.
// Optional opcode legality output guarded by IFA_ILLEGAL_CHECK_EN.
module ifetch_align_buffer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0060,
   parameter int unsigned HW_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_read,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_rdata,
   input  logic        imem_resp,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
`ifdef IFA_ILLEGAL_CHECK_EN
   output logic        instr_illegal,
`endif
   output logic        instr_compressed
);

   localparam int unsigned PW = $clog2(HW_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] ISSUE_MAX = CW'(HW_DEPTH - 2);

   logic [15:0]   hw_q [HW_DEPTH];
   logic [15:0]   hw_d [HW_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:1]   fetch_hw_q, fetch_hw_d;
   logic [31:2]   imem_addr_q, imem_addr_d;
   logic          imem_read_q, imem_read_d;
   logic          drop_q, drop_d;
   logic [31:0]   pc_q, pc_d;

   logic [15:0]   hw0, hw1;
   logic          head_c, head_ok, deq, accept, issue;
   logic [CW-1:0] deq_n, enq_n, count_after;
   logic [31:0]   redir_pc;

   always_comb begin
      hw0     = hw_q[rd_ptr_q];
      hw1     = hw_q[rd_ptr_q + PW'(1)];
      head_c  = (hw0[1:0] != 2'b11);
      head_ok = (count_q >= CW'(2)) || ((count_q != '0) && head_c);
   end

   assign instr_valid      = head_ok;
   assign instr_compressed = head_ok && head_c;
   assign instr            = !head_ok ? 32'h0 : (head_c ? {16'h0, hw0} : {hw1, hw0});
   assign instr_pc         = pc_q;
   assign imem_read        = imem_read_q;
   assign imem_address     = {imem_addr_q, 2'b00};

   assign redir_pc    = redirect_pc & 32'hFFFF_FFFE;
   assign deq         = head_ok && instr_ready && !redirect;
   assign deq_n       = !deq ? '0 : (head_c ? CW'(1) : CW'(2));
   // Data for a request that was overtaken by a redirect is never queued.
   assign accept      = imem_read_q && imem_resp && !drop_q && !redirect;
   assign enq_n       = !accept ? '0 : (fetch_hw_q[1] ? CW'(1) : CW'(2));
   assign count_after = count_q - deq_n;
   assign issue       = !imem_read_q && !redirect && (count_after <= ISSUE_MAX);

   always_comb begin
      // NOTE: every _d takes its hold value first, so no path leaves it unassigned and no latch is inferred.
      hw_d        = hw_q;
      rd_ptr_d    = rd_ptr_q + PW'(deq_n);
      wr_ptr_d    = wr_ptr_q + PW'(enq_n);
      count_d     = count_after + enq_n;
      pc_d        = deq ? pc_q + (head_c ? 32'd2 : 32'd4) : pc_q;
      fetch_hw_d  = fetch_hw_q;
      imem_addr_d = issue ? fetch_hw_q[31:2] : imem_addr_q;
      imem_read_d = imem_read_q ? !imem_resp : issue;
      drop_d      = drop_q;

      if (accept) begin
         if (fetch_hw_q[1]) begin
            hw_d[wr_ptr_q] = imem_rdata[31:16];
         end else begin
            hw_d[wr_ptr_q]           = imem_rdata[15:0];
            hw_d[wr_ptr_q + PW'(1)]  = imem_rdata[31:16];
         end
         fetch_hw_d = {fetch_hw_q[31:2] + 30'd1, 1'b0};
      end

      if (imem_read_q && imem_resp) begin
         drop_d = 1'b0;
      end else if (redirect && imem_read_q) begin
         drop_d = 1'b1;
      end

      if (redirect) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         pc_d       = redir_pc;
         fetch_hw_d = redir_pc[31:1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         fetch_hw_q  <= RESET_PC[31:1];
         imem_addr_q <= RESET_PC[31:2];
         imem_read_q <= 1'b0;
         drop_q      <= 1'b0;
         pc_q        <= RESET_PC;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         fetch_hw_q  <= fetch_hw_d;
         imem_addr_q <= imem_addr_d;
         imem_read_q <= imem_read_d;
         drop_q      <= drop_d;
         pc_q        <= pc_d;
      end
   end

   // NOTE: queue storage has no reset; count_q gates every read, so stale entries are never visible.
   always_ff @(posedge clk) begin
      hw_q <= hw_d;
   end

`ifdef IFA_ILLEGAL_CHECK_EN
   typedef enum logic [6:0] {
      OP_LUI   = 7'b0110111,
      OP_AUIPC = 7'b0010111,
      OP_JAL   = 7'b1101111,
      OP_JALR  = 7'b1100111,
      OP_BR    = 7'b1100011,
      OP_LOAD  = 7'b0000011,
      OP_STORE = 7'b0100011,
      OP_IMM   = 7'b0010011,
      OP_REG   = 7'b0110011,
      OP_CSR   = 7'b1110011
   } rv32i_opcode_t;

   logic op_legal;

   always_comb begin
      op_legal = 1'b0;
      case (instr[6:0])
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
         OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_CSR: op_legal = 1'b1;
         default:                                    op_legal = 1'b0;
      endcase
   end

   assign instr_illegal = instr_valid && !instr_compressed && !op_legal;
`endif

endmodule

// File: tb/tb_ifetch_align_buffer.sv
// Randomized bench for ifetch_align_buffer: memory responder plus a PC/byte-level
// model of the instruction stream. Define IFA_ILLEGAL_CHECK_EN to cover instr_illegal.
module tb_ifetch_align_buffer;

   localparam logic [31:0] RESET_PC = 32'h0000_0060;
   localparam int          HW_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_read;
   logic [31:0] imem_address;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_compressed;
`ifdef IFA_ILLEGAL_CHECK_EN
   logic        instr_illegal;
`endif

   ifetch_align_buffer #(.RESET_PC(RESET_PC), .HW_DEPTH(HW_DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_read        (imem_read),
      .imem_address     (imem_address),
      .imem_rdata       (imem_rdata),
      .imem_resp        (imem_resp),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .instr            (instr),
      .instr_pc         (instr_pc),
`ifdef IFA_ILLEGAL_CHECK_EN
      .instr_illegal    (instr_illegal),
`endif
      .instr_compressed (instr_compressed)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        comp;
      logic        ill;
   } rec_t;

   logic [31:0] mem [bit [31:0]];
   rec_t        acc_log [$];
   logic [31:0] req_log [$];

   // Model state: pc_m is the next PC decode should see, fe the byte address just past
   // the last halfword delivered, so (fe - pc_m)/2 is the number of halfwords held.
   logic [31:0] pc_m, fe, exp_fetch, req_addr, force_pc;
   bit          req_active, req_drop, resp_prev, redir_prev, force_redir;
   int          delay, rdy_pct, redir_pm, fixed_delay;

   function automatic logic [15:0] rand_hw();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
      else if (h[1:0] == 2'b11)      h[1:0] = 2'b01;
      return h;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = {rand_hw(), rand_hw()};
      return mem[a];
   endfunction

   function automatic logic [15:0] mem_hw(input logic [31:0] a);
      logic [31:0] w;
      w = mem_word({a[31:2], 2'b00});
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   function automatic bit op_legal(input logic [6:0] op);
      case (op)
         7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
         7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b1; imem_resp = 1'b0; imem_rdata = '0; redirect = 1'b0;
      redirect_pc = '0; instr_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      pc_m = RESET_PC; fe = RESET_PC; exp_fetch = RESET_PC & ~32'd3;
      req_active = 0; req_drop = 0; resp_prev = 0; redir_prev = 0; force_redir = 0;
      acc_log.delete(); req_log.delete();
      check("rst_imem_read", 32'(imem_read), 0);
      check("rst_imem_address", imem_address, RESET_PC & ~32'd3);
      check("rst_instr_valid", 32'(instr_valid), 0);
      check("rst_instr", instr, 0);
      check("rst_instr_pc", instr_pc, RESET_PC);
      check("rst_instr_compressed", 32'(instr_compressed), 0);
   endtask

   // One clock: observe post-edge outputs, drive inputs, advance the model, wait for next negedge.
   task automatic step();
      logic [31:0] occ, exp_ins, rpc;
      logic [15:0] h0;
      bit          avail, comp, redir, rdy;

      if (resp_prev) check("read_fall", 32'(imem_read), 0);
      resp_prev = 0;
      if (imem_read) begin
         if (!req_active) begin
            check("fetch_addr", imem_address, exp_fetch);
            req_log.push_back(imem_address);
            exp_fetch  = exp_fetch + 32'd4;
            req_active = 1; req_drop = 0; req_addr = imem_address;
            delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(3, 0));
         end else begin
            check("addr_stable", imem_address, req_addr);
         end
      end

      occ = (fe - pc_m) >> 1;
      avail = 0; comp = 0; exp_ins = '0;
      if (occ != 0) begin
         h0    = mem_hw(pc_m);
         comp  = (h0[1:0] != 2'b11);
         avail = comp || (occ >= 2);
         if (avail) exp_ins = comp ? {16'h0, h0} : {mem_hw(pc_m + 32'd2), h0};
      end
      check("instr_valid", 32'(instr_valid), 32'(avail));
      if (avail && instr_valid) begin
         check("instr", instr, exp_ins);
         check("instr_pc", instr_pc, pc_m);
         check("instr_compressed", 32'(instr_compressed), 32'(comp));
`ifdef IFA_ILLEGAL_CHECK_EN
         check("instr_illegal", 32'(instr_illegal), 32'(!comp && !op_legal(exp_ins[6:0])));
`endif
      end

      redir = 0; rpc = '0;
      if (force_redir) begin
         redir = 1; rpc = force_pc; force_redir = 0;
      end else if (!redir_prev && $urandom_range(999, 0) < redir_pm) begin
         redir = 1;
         if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
         else                           rpc = 32'h100 + 32'($urandom_range(511, 0));
      end
      rdy = ($urandom_range(99, 0) < rdy_pct);
      imem_resp  = 1'b0;
      imem_rdata = $urandom;
      if (req_active) begin
         if (delay == 0) begin
            imem_resp  = 1'b1;
            imem_rdata = mem_word(req_addr);
         end else begin
            delay--;
         end
      end
      redirect = redir; redirect_pc = rpc; instr_ready = rdy;

      if (redir) begin
         pc_m = rpc & ~32'd1; fe = pc_m; exp_fetch = rpc & ~32'd3;
         if (req_active) req_drop = 1;
         acc_log.delete(); req_log.delete();
      end else if (avail && rdy) begin
         acc_log.push_back('{pc: pc_m, ins: exp_ins, comp: comp, ill: !comp && !op_legal(exp_ins[6:0])});
         pc_m = pc_m + (comp ? 32'd2 : 32'd4);
      end
      if (imem_resp) begin
         if (!req_drop && !redir) begin
            fe = req_addr + 32'd4;
            check("queue_bound", 32'(((fe - pc_m) >> 1) <= HW_DEPTH), 1);
         end
         req_active = 0; resp_prev = 1;
      end
      redir_prev = redir;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic check_log(input string tag, input int i, input logic [31:0] pc, input logic [31:0] ins);
      check({tag, "_present"}, 32'(acc_log.size() > i), 1);
      if (acc_log.size() > i) begin
         check({tag, "_pc"}, acc_log[i].pc, pc);
         check({tag, "_instr"}, acc_log[i].ins, ins);
      end
   endtask

   initial begin
      bit found;
      rdy_pct = 100; redir_pm = 0; fixed_delay = 0;

      // Two 32-bit instructions from the reset PC.
      mem.delete(); mem[32'h60] = 32'h00A0_0093; mem[32'h64] = 32'h00B0_0113;
      do_reset();
      step();
      check("first_read", 32'(imem_read), 1);
      run(20);
      check_log("t1_a", 0, 32'h60, 32'h00A0_0093);
      check_log("t1_b", 1, 32'h64, 32'h00B0_0113);

      // Two compressed instructions in one word.
      mem.delete(); mem[32'h60] = 32'h4505_4501;
      do_reset();
      run(20);
      check_log("t2_a", 0, 32'h60, 32'h0000_4501);
      check_log("t2_b", 1, 32'h62, 32'h0000_4505);
      check("t2_next_fetch", (req_log.size() > 1) ? req_log[1] : 32'hDEAD_BEEF, 32'h64);

      // 32-bit instruction straddling a word boundary.
      mem.delete(); mem[32'h60] = 32'h0093_4501; mem[32'h64] = 32'h4581_00A0;
      fixed_delay = 2;
      do_reset();
      run(30);
      check_log("t3_a", 0, 32'h60, 32'h0000_4501);
      check_log("t3_b", 1, 32'h62, 32'h00A0_0093);
      check_log("t3_c", 2, 32'h66, 32'h0000_4581);

      // Redirect to an odd halfword while the fetch of 0x68 is outstanding.
      mem.delete(); fixed_delay = 3;
      do_reset();
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (req_active && req_addr == 32'h68 && delay >= 1) found = 1;
      end
      check("t4_reached_0x68", 32'(found), 1);
      force_redir = 1; force_pc = 32'h102;
      step();
      check("t4_read_held", 32'(imem_read), 1);
      check("t4_addr_held", imem_address, 32'h68);
      run(40);
      check("t4_refetch", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h100);
      check("t4_first_pc", (acc_log.size() > 0) ? acc_log[0].pc : 32'hDEAD_BEEF, 32'h102);

      // Decode stalled for 10 cycles: fetch must stop once the queue is full.
      mem.delete(); fixed_delay = 0;
      do_reset();
      run(10);
      rdy_pct = 0;
      run(10);
      check("t5_read_low", 32'(imem_read), 0);
      check("t5_valid_held", 32'(instr_valid), 1);
      rdy_pct = 100;
      run(10);

`ifdef IFA_ILLEGAL_CHECK_EN
      mem.delete(); mem[32'h60] = 32'h0000_007F; mem[32'h64] = 32'h0000_0013;
      do_reset();
      run(20);
      check("t6_illegal", (acc_log.size() > 0) ? 32'(acc_log[0].ill) : 32'hDEAD_BEEF, 1);
      check("t6_legal", (acc_log.size() > 1) ? 32'(acc_log[1].ill) : 32'hDEAD_BEEF, 0);
`endif

      // Random traffic: variable latency, backpressure, redirects including near 0xFFFF_FFFF.
      mem.delete(); fixed_delay = -1; rdy_pct = 70; redir_pm = 20;
      do_reset();
      run(3000);
      rdy_pct = 30; redir_pm = 40;
      run(3000);
      redir_pm = 0;
      do_reset();
      run(500);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
